mmio_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the FPro MMIO bus. It sits between the bus masters and the `mmio_sys_vanilla` MMIO subsystem. Master 0 is the processor and master 1 is an auxiliary master (DMA or debug bridge). The block accepts one transaction at a time and drives exactly one single-cycle FPro bus strobe per transaction. It registers the read data and returns a one-cycle `done` to the granted master. Selection between masters is either round-robin or fixed-priority.

---
 rtl/mmio_bus_arbiter_if.sv | 42 ++++
 rtl/mmio_bus_arbiter.sv | 106 ++++++++++
 tb/tb_mmio_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_arbiter_if.sv
// Master-side request/response and FPro bus signals for mmio_bus_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mmio_bus_arbiter_if;
    logic        m0_req;
    logic        m0_wr;
    logic [20:0] m0_addr;
    logic [31:0] m0_wr_data;
    logic        m0_done;
    logic [31:0] m0_rd_data;
    logic        m1_req;
    logic        m1_wr;
    logic [20:0] m1_addr;
    logic [31:0] m1_wr_data;
    logic        m1_done;
    logic [31:0] m1_rd_data;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic        busy;
    logic        owner;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wr_data,
        input  m1_req, m1_wr, m1_addr, m1_wr_data,
        input  mmio_rd_data,
        output m0_done, m0_rd_data, m1_done, m1_rd_data,
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        output busy, owner
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wr_data,
        output m1_req, m1_wr, m1_addr, m1_wr_data,
        output mmio_rd_data,
        input  m0_done, m0_rd_data, m1_done, m1_rd_data,
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        input  busy, owner
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter/sequencer for the FPro MMIO bus: one transaction at a time,
// one single-cycle strobe per transaction, registered read data and a done pulse.
module mmio_bus_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    mmio_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [20:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic        winner;

    // A lone requester wins outright; ties go by priority mode.
    always_comb begin
        if (bus.m0_req && bus.m1_req) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            winner = bus.m1_req;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d      = ISSUE;
                    owner_d      = winner;
                    last_grant_d = winner;
                    wr_d         = winner ? bus.m1_wr      : bus.m0_wr;
                    addr_d       = winner ? bus.m1_addr    : bus.m0_addr;
                    wdata_d      = winner ? bus.m1_wr_data : bus.m0_wr_data;
                end
            end
            ISSUE: begin
                state_d = RESP;
                if (!wr_q) begin
                    if (owner_q) begin
                        rd1_d = bus.mmio_rd_data;
                    end else begin
                        rd0_d = bus.mmio_rd_data;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign bus.mmio_cs      = (state_q == ISSUE);
    assign bus.mmio_wr      = (state_q == ISSUE) &&  wr_q;
    assign bus.mmio_rd      = (state_q == ISSUE) && !wr_q;
    assign bus.mmio_addr    = addr_q;
    assign bus.mmio_wr_data = wdata_q;
    assign bus.m0_done      = (state_q == RESP) && !owner_q;
    assign bus.m1_done      = (state_q == RESP) &&  owner_q;
    assign bus.m0_rd_data   = rd0_q;
    assign bus.m1_rd_data   = rd1_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.owner        = owner_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench for mmio_bus_arbiter: a round-robin and a fixed-priority
// instance, directed stimulus pushes expected bus transactions, a monitor checks.
module tb_mmio_bus_arbiter;

    typedef struct {
        bit          m;
        bit          wr;
        logic [20:0] addr;
        logic [31:0] wdata;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mmio_bus_arbiter_if bus0();
    mmio_bus_arbiter_if bus1();

    mmio_bus_arbiter #(.FIXED_PRIO(0)) dut_rr (.clk(clk), .reset(reset), .bus(bus0.slave));
    mmio_bus_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .reset(reset), .bus(bus1.slave));

    logic        req_v  [2][2];
    logic        wr_v   [2][2];
    logic [20:0] addr_v [2][2];
    logic [31:0] wd_v   [2][2];

    function automatic logic [31:0] rd_model(input logic [20:0] a);
        return {11'h000, a} ^ 32'h0000_0065;
    endfunction

    assign bus0.m0_req = req_v[0][0];  assign bus0.m0_wr = wr_v[0][0];
    assign bus0.m0_addr = addr_v[0][0]; assign bus0.m0_wr_data = wd_v[0][0];
    assign bus0.m1_req = req_v[0][1];  assign bus0.m1_wr = wr_v[0][1];
    assign bus0.m1_addr = addr_v[0][1]; assign bus0.m1_wr_data = wd_v[0][1];
    assign bus1.m0_req = req_v[1][0];  assign bus1.m0_wr = wr_v[1][0];
    assign bus1.m0_addr = addr_v[1][0]; assign bus1.m0_wr_data = wd_v[1][0];
    assign bus1.m1_req = req_v[1][1];  assign bus1.m1_wr = wr_v[1][1];
    assign bus1.m1_addr = addr_v[1][1]; assign bus1.m1_wr_data = wd_v[1][1];
    assign bus0.mmio_rd_data = rd_model(bus0.mmio_addr);
    assign bus1.mmio_rd_data = rd_model(bus1.mmio_addr);

    logic        cs_w [2], mwr_w [2], mrd_w [2], busy_w [2], own_w [2];
    logic [20:0] maddr_w [2];
    logic [31:0] mwd_w [2];
    logic        done_w [2][2];
    logic [31:0] rdd_w  [2][2];

    assign cs_w[0] = bus0.mmio_cs;     assign cs_w[1] = bus1.mmio_cs;
    assign mwr_w[0] = bus0.mmio_wr;    assign mwr_w[1] = bus1.mmio_wr;
    assign mrd_w[0] = bus0.mmio_rd;    assign mrd_w[1] = bus1.mmio_rd;
    assign busy_w[0] = bus0.busy;      assign busy_w[1] = bus1.busy;
    assign own_w[0] = bus0.owner;      assign own_w[1] = bus1.owner;
    assign maddr_w[0] = bus0.mmio_addr; assign maddr_w[1] = bus1.mmio_addr;
    assign mwd_w[0] = bus0.mmio_wr_data; assign mwd_w[1] = bus1.mmio_wr_data;
    assign done_w[0][0] = bus0.m0_done; assign done_w[0][1] = bus0.m1_done;
    assign done_w[1][0] = bus1.m0_done; assign done_w[1][1] = bus1.m1_done;
    assign rdd_w[0][0] = bus0.m0_rd_data; assign rdd_w[0][1] = bus0.m1_rd_data;
    assign rdd_w[1][0] = bus1.m0_rd_data; assign rdd_w[1][1] = bus1.m1_rd_data;

    exp_t        exp_q [2][$];
    int          total = 0;
    int          bad = 0;
    int          timeouts = 0;
    bit          fin_req = 1'b0;
    bit          fin_done = 1'b0;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s inst%0d actual=%h required=%h", name, i, act, req);
        end
    endtask

    // Monitor: pops an expectation on every strobe, then demands the matching done next cycle.
    initial begin
        bit          pend   [2];
        bit          pend_m [2];
        logic [31:0] rd_mdl [2][2];
        int          last_cs[2];
        int          cyc;
        exp_t        e;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pend_m[i] = 1'b0; last_cs[i] = -100;
            rd_mdl[i][0] = '0; rd_mdl[i][1] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    chk("rst_cs", i, 32'(cs_w[i]), 32'd0);
                    chk("rst_wr", i, 32'(mwr_w[i]), 32'd0);
                    chk("rst_rd", i, 32'(mrd_w[i]), 32'd0);
                    chk("rst_addr", i, 32'(maddr_w[i]), 32'd0);
                    chk("rst_wdata", i, mwd_w[i], 32'd0);
                    chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
                    chk("rst_owner", i, 32'(own_w[i]), 32'd0);
                    chk("rst_done0", i, 32'(done_w[i][0]), 32'd0);
                    chk("rst_done1", i, 32'(done_w[i][1]), 32'd0);
                    chk("rst_rdata0", i, rdd_w[i][0], 32'd0);
                    chk("rst_rdata1", i, rdd_w[i][1], 32'd0);
                    pend[i] = 1'b0;
                    rd_mdl[i][0] = '0;
                    rd_mdl[i][1] = '0;
                end else begin
                    chk("done0", i, 32'(done_w[i][0]), 32'(pend[i] && !pend_m[i]));
                    chk("done1", i, 32'(done_w[i][1]), 32'(pend[i] && pend_m[i]));
                    chk("busy", i, 32'(busy_w[i]), 32'(cs_w[i] || pend[i]));
                    if (pend[i]) begin
                        chk("rdata0", i, rdd_w[i][0], rd_mdl[i][0]);
                        chk("rdata1", i, rdd_w[i][1], rd_mdl[i][1]);
                    end
                    pend[i] = 1'b0;
                    if (cs_w[i]) begin
                        if (exp_q[i].size() == 0) begin
                            chk("unexpected_cs", i, 32'(cs_w[i]), 32'd0);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk("owner", i, 32'(own_w[i]), 32'(e.m));
                            chk("mmio_wr", i, 32'(mwr_w[i]), 32'(e.wr));
                            chk("mmio_rd", i, 32'(mrd_w[i]), 32'(!e.wr));
                            chk("mmio_addr", i, 32'(maddr_w[i]), 32'(e.addr));
                            chk("mmio_wdata", i, mwd_w[i], e.wdata);
                            if (e.gap != 0) begin
                                chk("strobe_gap", i, 32'(cyc - last_cs[i]), 32'(e.gap));
                            end
                            if (!e.wr) begin
                                rd_mdl[i][e.m] = rd_model(e.addr);
                            end
                            pend[i]   = 1'b1;
                            pend_m[i] = e.m;
                        end
                        last_cs[i] = cyc;
                    end
                end
            end
            if (fin_req && !fin_done) begin
                chk("leftover_exp0", 0, 32'(exp_q[0].size()), 32'd0);
                chk("leftover_exp1", 1, 32'(exp_q[1].size()), 32'd0);
                chk("done_timeouts", 0, 32'(timeouts), 32'd0);
                fin_done = 1'b1;
            end
        end
    end

    task automatic wait_done(input int i, input int m);
        int n;
        n = 0;
        while (done_w[i][m] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            timeouts++;
        end
    endtask

    task automatic run_master(input int i, input int m, input int n, input logic wr,
                              input logic [20:0] base, input logic [31:0] dbase);
        for (int k = 0; k < n; k++) begin
            wr_v[i][m]   = wr;
            addr_v[i][m] = base + 21'(4 * k);
            wd_v[i][m]   = dbase + 32'(k);
            req_v[i][m]  = 1'b1;
            @(negedge clk);
            wait_done(i, m);
        end
        req_v[i][m] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                req_v[i][m] = 1'b0; wr_v[i][m] = 1'b0;
                addr_v[i][m] = '0;  wd_v[i][m] = '0;
            end
        end
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);

        // single read, master 0
        exp_q[0].push_back('{m: 1'b0, wr: 1'b0, addr: 21'h000C0, wdata: 32'h0, gap: 0});
        run_master(0, 0, 1, 1'b0, 21'h000C0, 32'h0);
        repeat (2) @(negedge clk);

        // single write, master 1
        exp_q[0].push_back('{m: 1'b1, wr: 1'b1, addr: 21'h00080, wdata: 32'h0000_0F0F, gap: 0});
        run_master(0, 1, 1, 1'b1, 21'h00080, 32'h0000_0F0F);
        repeat (2) @(negedge clk);

        // round-robin contention: strict alternation starting with master 0
        for (int k = 0; k < 4; k++) begin
            exp_q[0].push_back('{m: 1'b0, wr: 1'b0, addr: 21'h00100 + 21'(4 * k),
                                 wdata: 32'(k), gap: (k == 0) ? 0 : 3});
            exp_q[0].push_back('{m: 1'b1, wr: 1'b1, addr: 21'h00200 + 21'(4 * k),
                                 wdata: 32'h1000 + 32'(k), gap: 3});
        end
        fork
            run_master(0, 0, 4, 1'b0, 21'h00100, 32'h0);
            run_master(0, 1, 4, 1'b1, 21'h00200, 32'h1000);
        join
        repeat (2) @(negedge clk);

        // fixed priority: master 0 served three times before master 1
        for (int k = 0; k < 3; k++) begin
            exp_q[1].push_back('{m: 1'b0, wr: 1'b0, addr: 21'h000C0 + 21'(4 * k),
                                 wdata: 32'h50 + 32'(k), gap: (k == 0) ? 0 : 3});
        end
        exp_q[1].push_back('{m: 1'b1, wr: 1'b1, addr: 21'h00300, wdata: 32'h0000_BEEF, gap: 3});
        fork
            run_master(1, 0, 3, 1'b0, 21'h000C0, 32'h50);
            run_master(1, 1, 1, 1'b1, 21'h00300, 32'h0000_BEEF);
        join
        repeat (2) @(negedge clk);

        // address change during ISSUE must not reach the bus
        exp_q[0].push_back('{m: 1'b0, wr: 1'b0, addr: 21'h00040, wdata: 32'h77, gap: 0});
        wr_v[0][0] = 1'b0; addr_v[0][0] = 21'h00040; wd_v[0][0] = 32'h77; req_v[0][0] = 1'b1;
        @(posedge clk);
        #1 addr_v[0][0] = 21'h00100;
        @(negedge clk);
        wait_done(0, 0);
        req_v[0][0] = 1'b0;
        repeat (2) @(negedge clk);

        // reset during master 1's strobe; afterwards master 0 wins the tie
        exp_q[0].push_back('{m: 1'b0, wr: 1'b0, addr: 21'h00044, wdata: 32'h0, gap: 0});
        exp_q[0].push_back('{m: 1'b1, wr: 1'b0, addr: 21'h00048, wdata: 32'h0, gap: 3});
        wr_v[0][0] = 1'b0; addr_v[0][0] = 21'h00044; wd_v[0][0] = 32'h0;
        wr_v[0][1] = 1'b0; addr_v[0][1] = 21'h00048; wd_v[0][1] = 32'h0; req_v[0][1] = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_v[0][0] = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        fork
            begin wait_done(0, 0); req_v[0][0] = 1'b0; end
            begin wait_done(0, 1); req_v[0][1] = 1'b0; end
        join
        repeat (3) @(negedge clk);

        #1 fin_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog inst0 actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
